// File: rtl/asynch_channel_arbiter.sv
// Round-robin packet arbiter feeding one asynch channel sender; one IDLE bubble per packet, then beats pass through combinationally.
// Backpressure: ch_ready is routed only to the granted requester; a watchdog drops a grant whose owner stalls mid-packet.
module asynch_channel_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 4,
  parameter int ID_WIDTH    = 2,
  parameter int STALL_LIMIT = 15
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ch_valid,
  output logic [DATA_WIDTH-1:0]         ch_data,
  output logic [ID_WIDTH-1:0]           ch_id,
  output logic                          ch_last,
  input  logic                          ch_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          abort_pulse
);

  localparam int CNT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam int SH_W  = ID_WIDTH + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_nxt;
  logic [ID_WIDTH-1:0]     grant_idx, grant_idx_nxt;
  logic [ID_WIDTH-1:0]     rr_ptr, rr_ptr_nxt;
  logic [ID_WIDTH-1:0]     winner;
  logic [CNT_W-1:0]        stall_cnt, stall_cnt_nxt;
  logic                    abort_nxt;
  logic                    found;
  logic [2*NUM_REQ-1:0]    dbl;
  logic [NUM_REQ-1:0]      rot;
  logic [SH_W-1:0]         shamt;
  int                      off;
  int                      sum;
  logic                    g_valid, g_last;
  logic [DATA_WIDTH-1:0]   g_data;

  // Rotate requests so bit 0 is the requester just after rr_ptr, then take the lowest set bit.
  always_comb begin
    shamt  = SH_W'(rr_ptr) + SH_W'(1);
    dbl    = {req_valid, req_valid} >> shamt;
    rot    = dbl[NUM_REQ-1:0];
    found  = 1'b0;
    off    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(rr_ptr) + 1 + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    winner = ID_WIDTH'(sum);
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    grant     = '0;
    req_ready = '0;
    ch_valid  = 1'b0;
    ch_data   = '0;
    ch_id     = '0;
    ch_last   = 1'b0;
    if (state == LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++) grant[i] = (grant_idx == ID_WIDTH'(i));
      req_ready = grant & {NUM_REQ{ch_ready}};
      ch_valid  = g_valid;
      ch_data   = g_data;
      ch_last   = g_last;
      ch_id     = grant_idx;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    stall_cnt_nxt = stall_cnt;
    abort_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = LOCKED;
          grant_idx_nxt = winner;
          stall_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (g_valid) stall_cnt_nxt = '0;
        else if (stall_cnt != '1) stall_cnt_nxt = stall_cnt + 1'b1;
        // Completion wins over the watchdog when both land in the same cycle.
        if (g_valid && ch_ready && g_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_idx;
        end else if ((STALL_LIMIT > 0) && !g_valid && (stall_cnt_nxt == CNT_W'(STALL_LIMIT))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_idx;
          abort_nxt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state       <= IDLE;
      grant_idx   <= '0;
      rr_ptr      <= ID_WIDTH'(NUM_REQ - 1);
      stall_cnt   <= '0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_idx   <= grant_idx_nxt;
      rr_ptr      <= rr_ptr_nxt;
      stall_cnt   <= stall_cnt_nxt;
      abort_pulse <= abort_nxt;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstnn) $onehot0(grant));
  a_idle_quiet:   assert property (@(posedge clk) disable iff (!rstnn) (state == IDLE) |-> !ch_valid);
  a_ready_owner:  assert property (@(posedge clk) disable iff (!rstnn) (req_ready & ~grant) == '0);

endmodule

// File: tb/tb_asynch_channel_arbiter.sv
// Bench for asynch_channel_arbiter: directed scenarios plus randomized packet traffic against a round-robin packet-order model.
module tb_asynch_channel_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int DATA_WIDTH  = 4;
  localparam int ID_WIDTH    = 2;
  localparam int STALL_LIMIT = 15;
  localparam int MAX_CYC     = 2000;

  logic                          clk;
  logic                          rstnn;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          ch_valid;
  logic [DATA_WIDTH-1:0]         ch_data;
  logic [ID_WIDTH-1:0]           ch_id;
  logic                          ch_last;
  logic                          ch_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          abort_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]           sb [$];
  logic [31:0]           mon_exp;
  int                    pkt_len [NUM_REQ][$];
  logic [DATA_WIDTH-1:0] bdata   [NUM_REQ][$];
  bit                    blast   [NUM_REQ][$];

  asynch_channel_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_id(ch_id), .ch_last(ch_last), .ch_ready(ch_ready),
    .grant(grant), .abort_pulse(abort_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int id, input logic [DATA_WIDTH-1:0] d, input logic l);
    return (32'(id) << (DATA_WIDTH + 1)) | (32'(l) << DATA_WIDTH) | 32'(d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [DATA_WIDTH-1:0] d, input logic l);
    req_valid[i] = v;
    req_last[i]  = l;
    req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  task automatic do_reset();
    rstnn     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    ch_ready  = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rstnn = 1'b1;
  endtask

  // Monitor: every accepted channel beat must be the next one the model predicted.
  always @(negedge clk) begin
    if (rstnn) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("ready_not_granted", 32'(req_ready & ~grant), 32'd0);
      if (ch_valid && ch_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", enc(int'(ch_id), ch_data, ch_last), 32'hFFFF_FFFF);
        end else begin
          mon_exp = sb.pop_front();
          check("beat", enc(int'(ch_id), ch_data, ch_last), mon_exp);
        end
      end
    end
  end

  task automatic clear_pkts();
    for (int i = 0; i < NUM_REQ; i++) begin
      pkt_len[i].delete();
      bdata[i].delete();
      blast[i].delete();
    end
  endtask

  task automatic add_pkt(input int i, input int len, input bit rnd_data);
    pkt_len[i].push_back(len);
    for (int b = 0; b < len; b++) begin
      bdata[i].push_back(rnd_data ? DATA_WIDTH'($urandom_range(0, 15)) : DATA_WIDTH'(i * 4 + b));
      blast[i].push_back(b == len - 1);
    end
  endtask

  // Packet-level model: with every backlogged requester holding valid, packets leave in
  // round-robin order starting after the last winner; each packet is sent whole.
  task automatic build_model();
    int ptr;
    int left;
    int c;
    int t;
    int pk[NUM_REQ];
    int bp[NUM_REQ];
    ptr  = NUM_REQ - 1;
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pk[i] = 0;
      bp[i] = 0;
      left += pkt_len[i].size();
    end
    while (left > 0) begin
      c = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        t = (ptr + k) % NUM_REQ;
        if (c < 0 && pk[t] < pkt_len[t].size()) c = t;
      end
      for (int b = 0; b < pkt_len[c][pk[c]]; b++) begin
        sb.push_back(enc(c, bdata[c][bp[c]], blast[c][bp[c]]));
        bp[c]++;
      end
      pk[c]++;
      ptr = c;
      left--;
    end
  endtask

  task automatic run_traffic(input bit rnd);
    int  pos[NUM_REQ];
    int  gap[NUM_REQ];
    bit  hs[NUM_REQ];
    int  cyc;
    bit  busy;
    cyc  = 0;
    busy = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      gap[i] = 0;
    end
    while (busy && cyc < MAX_CYC) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pos[i] < bdata[i].size()) begin
          if (gap[i] > 0) begin
            req_valid[i] = 1'b0;
            gap[i]--;
          end else begin
            set_req(i, 1'b1, bdata[i][pos[i]], blast[i][pos[i]]);
          end
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      ch_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) hs[i] = req_valid[i] && req_ready[i];
      step();
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) begin
          // Gaps only inside a packet, so idle-time snapshots are deterministic.
          if (rnd && !blast[i][pos[i]]) gap[i] = $urandom_range(0, 3);
          pos[i]++;
        end
      end
      busy = (sb.size() != 0);
      for (int i = 0; i < NUM_REQ; i++) if (pos[i] < bdata[i].size()) busy = 1'b1;
    end
    check("traffic_done", 32'(busy), 32'd0);
    req_valid = '0;
    ch_ready  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state while inputs are busy.
    rstnn     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    ch_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_ch_valid", 32'(ch_valid), 32'd0);
    check("rst_ch_data", 32'(ch_data), 32'd0);
    check("rst_ch_id", 32'(ch_id), 32'd0);
    check("rst_ch_last", 32'(ch_last), 32'd0);
    check("rst_abort", 32'(abort_pulse), 32'd0);

    // Two single-beat packets, one bubble before each grant.
    do_reset();
    set_req(0, 1'b1, 4'h3, 1'b1);
    set_req(2, 1'b1, 4'h7, 1'b1);
    ch_ready = 1'b1;
    sb.push_back(enc(0, 4'h3, 1'b1));
    sb.push_back(enc(2, 4'h7, 1'b1));
    @(negedge clk);
    check("t1_bubble0", 32'(grant), 32'd0);
    step();
    @(negedge clk);
    check("t1_grant0", 32'(grant), 32'b0001);
    check("t1_id0", 32'(ch_id), 32'd0);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_bubble1", 32'(grant), 32'd0);
    step();
    @(negedge clk);
    check("t1_grant2", 32'(grant), 32'b0100);
    check("t1_id2", 32'(ch_id), 32'd2);
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("t1_drain", 32'(sb.size()), 32'd0);

    // All requesters, two 3-beat packets each, no backpressure.
    do_reset();
    clear_pkts();
    for (int i = 0; i < NUM_REQ; i++) begin
      add_pkt(i, 3, 1'b0);
      add_pkt(i, 3, 1'b0);
    end
    build_model();
    run_traffic(1'b0);

    // Backpressure holds the beat and req_ready follows ch_ready.
    do_reset();
    set_req(1, 1'b1, 4'hA, 1'b0);
    sb.push_back(enc(1, 4'hA, 1'b0));
    sb.push_back(enc(1, 4'hB, 1'b1));
    step();
    ch_ready = 1'b1;
    @(negedge clk);
    check("t3_data_a", 32'(ch_data), 32'hA);
    check("t3_ready_hi", 32'(req_ready), 32'b0010);
    step();
    set_req(1, 1'b1, 4'hB, 1'b1);
    ch_ready = 1'b0;
    @(negedge clk);
    check("t3_data_b", 32'(ch_data), 32'hB);
    check("t3_ready_lo", 32'(req_ready), 32'd0);
    check("t3_valid", 32'(ch_valid), 32'd1);
    step();
    @(negedge clk);
    check("t3_hold_b", 32'(ch_data), 32'hB);
    check("t3_hold_grant", 32'(grant), 32'b0010);
    step();
    ch_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_back", 32'(req_ready), 32'b0010);
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t3_done_grant", 32'(grant), 32'd0);
    check("t3_no_abort", 32'(abort_pulse), 32'd0);
    check("t3_drain", 32'(sb.size()), 32'd0);

    // Watchdog: req3 stalls after one beat, pending req0 wins afterwards.
    do_reset();
    set_req(3, 1'b1, 4'h5, 1'b0);
    ch_ready = 1'b1;
    sb.push_back(enc(3, 4'h5, 1'b0));
    sb.push_back(enc(0, 4'h9, 1'b1));
    step();
    set_req(0, 1'b1, 4'h9, 1'b1);
    step();
    req_valid[3] = 1'b0;
    for (int k = 1; k < STALL_LIMIT; k++) begin
      step();
      @(negedge clk);
      check("t4_still_locked", 32'(grant), 32'b1000);
      check("t4_no_early_abort", 32'(abort_pulse), 32'd0);
    end
    step();
    @(negedge clk);
    check("t4_abort", 32'(abort_pulse), 32'd1);
    check("t4_released", 32'(grant), 32'd0);
    step();
    @(negedge clk);
    check("t4_abort_one_cycle", 32'(abort_pulse), 32'd0);
    check("t4_next_grant", 32'(grant), 32'b0001);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t4_drain", 32'(sb.size()), 32'd0);

    // Last beat lands on the cycle the watchdog would have fired.
    do_reset();
    set_req(1, 1'b1, 4'hC, 1'b0);
    ch_ready = 1'b1;
    sb.push_back(enc(1, 4'hC, 1'b0));
    sb.push_back(enc(1, 4'hD, 1'b1));
    step();
    step();
    req_valid[1] = 1'b0;
    repeat (STALL_LIMIT - 1) step();
    set_req(1, 1'b1, 4'hD, 1'b1);
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("t6_no_abort", 32'(abort_pulse), 32'd0);
    check("t6_idle", 32'(grant), 32'd0);
    check("t6_drain", 32'(sb.size()), 32'd0);

    // Reset mid-packet with req2 granted.
    do_reset();
    set_req(2, 1'b1, 4'h6, 1'b0);
    step();
    @(negedge clk);
    check("t5_locked", 32'(grant), 32'b0100);
    #2;
    rstnn = 1'b0;
    #1;
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_valid", 32'(ch_valid), 32'd0);
    req_valid = '0;
    set_req(0, 1'b1, 4'h4, 1'b1);
    set_req(2, 1'b1, 4'h6, 1'b0);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    rstnn    = 1'b1;
    ch_ready = 1'b1;
    sb.push_back(enc(0, 4'h4, 1'b1));
    @(negedge clk);
    check("t5_bubble", 32'(grant), 32'd0);
    step();
    @(negedge clk);
    check("t5_req0_first", 32'(grant), 32'b0001);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_drain", 32'(sb.size()), 32'd0);

    // Randomized packets, lengths, payloads, gaps and backpressure.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      clear_pkts();
      for (int i = 0; i < NUM_REQ; i++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) add_pkt(i, $urandom_range(1, 4), 1'b1);
      end
      build_model();
      run_traffic(1'b1);
      @(negedge clk);
      check("rand_abort_quiet", 32'(abort_pulse), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asynch_channel_arbiter.md
Name: asynch_channel_arbiter

Overview:
- Round-robin arbiter that shares one clock-domain-crossing transmit channel among NUM_REQ local requesters.
- Sits in the source clock domain, in front of the asynch channel sender. It grants whole packets, delimited by a last flag, and passes the winner's beats through with its source ID.
- A watchdog releases a grant whose owner stalls mid-packet.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 4, payload bits per beat.
- ID_WIDTH, 2, width of source ID; must satisfy 2**ID_WIDTH >= NUM_REQ.
- STALL_LIMIT, 15, idle cycles tolerated inside a locked packet before forced release; 0 disables the watchdog.

Ports:
- clk  input  1  clock.
- rstnn  input  1  reset; the clock is single, the reset asynchronous and active-low.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_last  input  NUM_REQ  per-requester last beat of packet.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester beat accept.
- ch_valid  output  1  channel beat valid.
- ch_data  output  DATA_WIDTH  channel payload.
- ch_id  output  ID_WIDTH  index of the granted requester.
- ch_last  output  1  channel last beat.
- ch_ready  input  1  channel accept from the asynch sender.
- grant  output  NUM_REQ  one-hot current grant; 0 when idle.
- abort_pulse  output  1  one-cycle pulse on watchdog release.

Behaviour:
- FSM states: IDLE, LOCKED. Registers: state, grant_idx, rr_ptr, stall_cnt, abort_pulse.
- Reset (asynchronous, rstnn=0):
  - state=IDLE, grant=0, grant_idx=0, rr_ptr=NUM_REQ-1, stall_cnt=0, abort_pulse=0.
  - All req_ready=0, ch_valid=0, ch_data=0, ch_id=0, ch_last=0.
  - Reset mid-packet drops the grant immediately; no beat completes.
- IDLE:
  - All outputs are inactive; no beat is transferred.
  - If any req_valid is set, the winner is the first set bit scanning upward from rr_ptr+1, modulo NUM_REQ.
  - Next cycle: state=LOCKED, grant_idx=winner, stall_cnt=0.
  - Arbitration costs exactly one bubble cycle per packet.
- LOCKED, with g=grant_idx:
  - ch_valid=req_valid[g], ch_data=req_data[g], ch_last=req_last[g], ch_id=g. These paths are combinational pass-through.
  - req_ready[g]=ch_ready; req_ready of every other requester is 0.
  - A beat transfers when ch_valid && ch_ready.
  - A transfer with ch_last=1 returns the FSM to IDLE and sets rr_ptr=g.
  - A 1-beat packet (valid and last together) is legal.
- Watchdog (STALL_LIMIT>0):
  - In LOCKED, stall_cnt increments each cycle req_valid[g]=0 and clears on any cycle req_valid[g]=1.
  - Reaching STALL_LIMIT with req_valid[g] still 0 forces IDLE, sets rr_ptr=g and pulses abort_pulse for 1 cycle.
  - stall_cnt saturates and never wraps.
  - Backpressure (ch_ready=0 with valid=1) never counts as a stall.
- Requester rules:
  - A requester holds valid, data and last stable until ready.
  - Other requesters' valid/data changes never affect the channel outputs while locked.
  - Requests arriving during LOCKED wait; the rotation guarantees each waiting requester is served within NUM_REQ-1 packets.
- Simultaneous events:
  - A last-beat handshake and the watchdog threshold in the same cycle count as normal completion; no abort_pulse.
  - Arbitration sees only the IDLE-cycle req_valid snapshot.
- Assertions: grant is one-hot or zero; ch_valid=0 in IDLE; req_ready is never set for a non-granted index.

Test Plan:
- Reset then req_valid=4'b0101, each requester sends a 1-beat packet, ch_ready=1 -> req0 granted cycle 2, ch_id=0; then req2, ch_id=2. Each grant is preceded by one IDLE bubble.
- All four requesters continuously send 3-beat packets, ch_ready=1 -> ch_id sequence 0,1,2,3,0, each exactly 3 beats. ch_last on the 3rd beat; no interleaving.
- req1 locked, ch_ready toggles 1,0,0,1 with req_data=4'hA,4'hB -> data stays 4'hB while stalled and req_ready[1] mirrors ch_ready. stall_cnt stays 0.
- STALL_LIMIT=15, req3 sends 1 non-last beat then drops valid -> after 15 idle cycles, abort_pulse=1 for 1 cycle and state=IDLE. A pending req0 is granted next.
- rstnn asserted low mid-packet with req2 granted -> grant=0, ch_valid=0 immediately. After release, req0 wins first if valid.
- Last beat and watchdog threshold coincide -> clean completion, abort_pulse stays 0.
